// File: rtl/load_store_unit.sv
// load_store_unit: RV32I MEM-stage load/store sequencer with alignment/funct3 checks, byte lanes and bus timeout.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid_MEM,
  input  logic             i_mem_read_MEM,
  input  logic             i_mem_write_MEM,
  input  logic [2:0]       i_funct3_MEM,
  input  logic [WIDTH-1:0] i_alu_result_MEM,
  input  logic [WIDTH-1:0] i_write_data_MEM,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [WIDTH-1:0] o_dmem_addr,
  output logic [3:0]       o_dmem_be,
  output logic [WIDTH-1:0] o_dmem_wdata,
  input  logic             i_dmem_ready,
  input  logic [WIDTH-1:0] i_dmem_rdata,
  output logic [WIDTH-1:0] o_read_data_MEM,
  output logic             o_done_MEM,
  output logic             o_stall_MEM,
  output logic             o_fault_MEM
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [1:0] off;
  logic [2:0] f3_q;
  logic we_q;
  logic [31:0] cnt;
  logic accepted, f3_ok, aligned, legal, fault_set, timeout, ready;
  logic [WIDTH-1:0] shifted, fmt, repl;
  assign accepted  = i_valid_MEM & (i_mem_read_MEM ^ i_mem_write_MEM);
  assign f3_ok     = i_mem_read_MEM ? (i_funct3_MEM[1:0] != 2'b11 && !(i_funct3_MEM[2] && i_funct3_MEM[1]))
                                    : (!i_funct3_MEM[2] && i_funct3_MEM[1:0] != 2'b11);
  assign aligned   = i_funct3_MEM[1:0] == 2'b01 ? !i_alu_result_MEM[0] :
                     i_funct3_MEM[1:0] == 2'b10 ? i_alu_result_MEM[1:0] == 2'b00 : 1'b1;
  assign legal     = state == IDLE && accepted && f3_ok && aligned;
  // Any read/write request that is not a legal single access faults, including read+write together.
  assign fault_set = state == IDLE && i_valid_MEM && (i_mem_read_MEM | i_mem_write_MEM) && !legal;
  assign ready     = state == BUSY && i_dmem_ready;
  assign timeout   = state == BUSY && !i_dmem_ready && cnt == 32'(TIMEOUT - 1);
  assign repl      = i_funct3_MEM[1:0] == 2'b00 ? {4{i_write_data_MEM[7:0]}} :
                     i_funct3_MEM[1:0] == 2'b01 ? {2{i_write_data_MEM[15:0]}} : i_write_data_MEM;
  assign shifted   = i_dmem_rdata >> {off, 3'b000};
  assign fmt       = f3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                     f3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                     f3_q == 3'b100 ? {24'b0, shifted[7:0]} :
                     f3_q == 3'b101 ? {16'b0, shifted[15:0]} : i_dmem_rdata;
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = legal ? BUSY : IDLE;
      BUSY: state_n = i_dmem_ready ? DONE : timeout ? IDLE : BUSY;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    o_dmem_req  = state == BUSY;
    o_dmem_we   = state == BUSY && we_q;
    o_dmem_be   = state != BUSY ? 4'b0000 :
                  !we_q || f3_q[1:0] == 2'b10 ? 4'b1111 :
                  f3_q[1:0] == 2'b01 ? 4'b0011 << off : 4'b0001 << off;
    o_done_MEM  = state == DONE;
    o_stall_MEM = legal || state == BUSY;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dmem_addr     <= '0;
      o_dmem_wdata    <= '0;
      o_read_data_MEM <= '0;
      o_fault_MEM     <= 1'b0;
      off             <= 2'b00;
      f3_q            <= 3'b000;
      we_q            <= 1'b0;
      cnt             <= '0;
    end else begin
      o_fault_MEM <= fault_set | timeout;
      cnt         <= state == BUSY ? cnt + 32'd1 : 32'd0;
      if (legal) begin
        o_dmem_addr  <= {i_alu_result_MEM[WIDTH-1:2], 2'b00};
        o_dmem_wdata <= repl;
        off          <= i_alu_result_MEM[1:0];
        f3_q         <= i_funct3_MEM;
        we_q         <= i_mem_write_MEM;
      end
      if (ready && !we_q) o_read_data_MEM <= fmt;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit with hand-computed expectations (TIMEOUT=4).
module tb_load_store_unit;
  logic i_clk, i_rst, i_valid_MEM, i_mem_read_MEM, i_mem_write_MEM, i_dmem_ready;
  logic [2:0] i_funct3_MEM;
  logic [31:0] i_alu_result_MEM, i_write_data_MEM, i_dmem_rdata;
  logic o_dmem_req, o_dmem_we, o_done_MEM, o_stall_MEM, o_fault_MEM;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_read_data_MEM;
  logic [3:0] o_dmem_be;
  int n_cmp = 0;
  int n_err = 0;
  load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid_MEM(i_valid_MEM), .i_mem_read_MEM(i_mem_read_MEM),
    .i_mem_write_MEM(i_mem_write_MEM), .i_funct3_MEM(i_funct3_MEM), .i_alu_result_MEM(i_alu_result_MEM),
    .i_write_data_MEM(i_write_data_MEM), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ready(i_dmem_ready), .i_dmem_rdata(i_dmem_rdata), .o_read_data_MEM(o_read_data_MEM),
    .o_done_MEM(o_done_MEM), .o_stall_MEM(o_stall_MEM), .o_fault_MEM(o_fault_MEM)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic req_in(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    i_valid_MEM = 1'b1; i_mem_read_MEM = rd; i_mem_write_MEM = wr;
    i_funct3_MEM = f3; i_alu_result_MEM = a; i_write_data_MEM = wd;
    #1;
  endtask
  task automatic idle_in;
    i_valid_MEM = 1'b0; i_mem_read_MEM = 1'b0; i_mem_write_MEM = 1'b0;
  endtask
  task automatic test_reset;
    i_rst = 1'b1;
    tick; tick;
    i_rst = 1'b0;
    n_cmp++; if (o_dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", o_dmem_req); end
    n_cmp++; if (o_dmem_be !== 4'b0) begin n_err++; $display("FAIL reset_be got %b want 0000", o_dmem_be); end
    n_cmp++; if (o_dmem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", o_dmem_addr); end
    n_cmp++; if (o_dmem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got %h want 0", o_dmem_wdata); end
    n_cmp++; if (o_read_data_MEM !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", o_read_data_MEM); end
    n_cmp++; if ({o_done_MEM, o_fault_MEM, o_stall_MEM, o_dmem_we} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {o_done_MEM, o_fault_MEM, o_stall_MEM, o_dmem_we}); end
  endtask
  task automatic test_lb;
    req_in(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
    n_cmp++; if ({o_stall_MEM, o_dmem_req} !== 2'b10) begin n_err++; $display("FAIL lb_accept stall/req got %b want 10", {o_stall_MEM, o_dmem_req}); end
    tick; idle_in;
    n_cmp++; if (o_dmem_addr !== 32'h0000_1000) begin n_err++; $display("FAIL lb_addr got %h want 00001000", o_dmem_addr); end
    n_cmp++; if ({o_dmem_req, o_dmem_we, o_dmem_be, o_stall_MEM} !== 7'b1011111) begin n_err++; $display("FAIL lb_busy req/we/be/stall got %b want 1011111", {o_dmem_req, o_dmem_we, o_dmem_be, o_stall_MEM}); end
    tick;
    n_cmp++; if ({o_dmem_req, o_done_MEM} !== 2'b10) begin n_err++; $display("FAIL lb_wait req/done got %b want 10", {o_dmem_req, o_done_MEM}); end
    i_dmem_ready = 1'b1; i_dmem_rdata = 32'h80FF_0000;
    tick; i_dmem_ready = 1'b0;
    n_cmp++; if (o_read_data_MEM !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data got %h want ffffff80", o_read_data_MEM); end
    n_cmp++; if ({o_done_MEM, o_dmem_req, o_stall_MEM} !== 3'b100) begin n_err++; $display("FAIL lb_done done/req/stall got %b want 100", {o_done_MEM, o_dmem_req, o_stall_MEM}); end
    tick;
    n_cmp++; if (o_done_MEM !== 1'b0) begin n_err++; $display("FAIL lb_done_width got %b want 0", o_done_MEM); end
  endtask
  task automatic test_sh;
    req_in(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
    tick; idle_in;
    n_cmp++; if (o_dmem_be !== 4'b1100) begin n_err++; $display("FAIL sh_be got %b want 1100", o_dmem_be); end
    n_cmp++; if (o_dmem_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata got %h want abcdabcd", o_dmem_wdata); end
    n_cmp++; if ({o_dmem_we, o_stall_MEM, o_dmem_addr} !== {2'b11, 32'h0000_2000}) begin n_err++; $display("FAIL sh_we_stall_addr got %b %b %h want 1 1 00002000", o_dmem_we, o_stall_MEM, o_dmem_addr); end
    i_dmem_ready = 1'b1; i_dmem_rdata = 32'h5555_5555;
    tick; i_dmem_ready = 1'b0;
    n_cmp++; if ({o_done_MEM, o_stall_MEM, o_dmem_we} !== 3'b100) begin n_err++; $display("FAIL sh_done done/stall/we got %b want 100", {o_done_MEM, o_stall_MEM, o_dmem_we}); end
    n_cmp++; if (o_read_data_MEM !== 32'hFFFF_FF80) begin n_err++; $display("FAIL sh_rdata_kept got %h want ffffff80", o_read_data_MEM); end
    tick;
  endtask
  task automatic test_misaligned;
    req_in(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    n_cmp++; if ({o_stall_MEM, o_dmem_req} !== 2'b00) begin n_err++; $display("FAIL mis_stall/req got %b want 00", {o_stall_MEM, o_dmem_req}); end
    tick; idle_in; #1;
    n_cmp++; if ({o_fault_MEM, o_dmem_req, o_stall_MEM} !== 3'b100) begin n_err++; $display("FAIL mis_fault fault/req/stall got %b want 100", {o_fault_MEM, o_dmem_req, o_stall_MEM}); end
    tick;
    n_cmp++; if (o_fault_MEM !== 1'b0) begin n_err++; $display("FAIL mis_fault_width got %b want 0", o_fault_MEM); end
    req_in(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0);
    tick; idle_in; #1;
    n_cmp++; if ({o_fault_MEM, o_dmem_req} !== 2'b10) begin n_err++; $display("FAIL bad_f3_store fault/req got %b want 10", {o_fault_MEM, o_dmem_req}); end
    tick;
  endtask
  task automatic test_both;
    req_in(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0);
    n_cmp++; if ({o_stall_MEM, o_dmem_req} !== 2'b00) begin n_err++; $display("FAIL both_stall/req got %b want 00", {o_stall_MEM, o_dmem_req}); end
    tick; idle_in; #1;
    n_cmp++; if ({o_fault_MEM, o_dmem_req, o_dmem_we, o_dmem_be} !== 7'b1000000) begin n_err++; $display("FAIL both_fault fault/req/we/be got %b want 1000000", {o_fault_MEM, o_dmem_req, o_dmem_we, o_dmem_be}); end
    tick;
  endtask
  task automatic test_timeout;
    req_in(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0);
    tick; idle_in;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({o_dmem_req, o_fault_MEM} !== 2'b10) begin n_err++; $display("FAIL to_busy_%0d req/fault got %b want 10", i, {o_dmem_req, o_fault_MEM}); end
      tick;
    end
    n_cmp++; if ({o_dmem_req, o_fault_MEM, o_done_MEM, o_stall_MEM} !== 4'b0100) begin n_err++; $display("FAIL to_expire req/fault/done/stall got %b want 0100", {o_dmem_req, o_fault_MEM, o_done_MEM, o_stall_MEM}); end
    n_cmp++; if (o_read_data_MEM !== 32'hFFFF_FF80) begin n_err++; $display("FAIL to_rdata_kept got %h want ffffff80", o_read_data_MEM); end
    tick;
    n_cmp++; if ({o_fault_MEM, o_done_MEM, o_dmem_req} !== 3'b000) begin n_err++; $display("FAIL to_after fault/done/req got %b want 000", {o_fault_MEM, o_done_MEM, o_dmem_req}); end
  endtask
  task automatic test_reset_busy;
    req_in(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    tick; idle_in;
    tick;
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0; i_dmem_ready = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++; if ({o_dmem_req, o_done_MEM} !== 2'b00) begin n_err++; $display("FAIL rstb_req/done got %b want 00", {o_dmem_req, o_done_MEM}); end
    tick;
    n_cmp++; if ({o_done_MEM, o_dmem_req} !== 2'b00) begin n_err++; $display("FAIL rstb_ready_ignored done/req got %b want 00", {o_done_MEM, o_dmem_req}); end
    n_cmp++; if (o_read_data_MEM !== 32'h0) begin n_err++; $display("FAIL rstb_rdata got %h want 0", o_read_data_MEM); end
    i_dmem_ready = 1'b0;
    tick;
  endtask
  task automatic test_back_to_back;
    req_in(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5);
    tick;
    n_cmp++; if ({o_dmem_be, o_dmem_wdata} !== {4'b0010, 32'hA5A5_A5A5}) begin n_err++; $display("FAIL sb_be/wdata got %b %h want 0010 a5a5a5a5", o_dmem_be, o_dmem_wdata); end
    i_dmem_ready = 1'b1;
    req_in(1'b1, 1'b0, 3'b100, 32'h0000_3001, 32'h0);
    tick; i_dmem_ready = 1'b0; #1;
    n_cmp++; if ({o_done_MEM, o_stall_MEM, o_dmem_req} !== 3'b100) begin n_err++; $display("FAIL b2b_done done/stall/req got %b want 100", {o_done_MEM, o_stall_MEM, o_dmem_req}); end
    tick;
    n_cmp++; if ({o_dmem_req, o_stall_MEM, o_done_MEM} !== 3'b010) begin n_err++; $display("FAIL b2b_idle req/stall/done got %b want 010", {o_dmem_req, o_stall_MEM, o_done_MEM}); end
    tick; idle_in;
    n_cmp++; if ({o_dmem_req, o_dmem_we, o_dmem_be} !== 6'b101111) begin n_err++; $display("FAIL lbu_busy req/we/be got %b want 101111", {o_dmem_req, o_dmem_we, o_dmem_be}); end
    i_dmem_ready = 1'b1; i_dmem_rdata = 32'h0000_A500;
    tick; i_dmem_ready = 1'b0;
    n_cmp++; if ({o_done_MEM, o_read_data_MEM} !== {1'b1, 32'h0000_00A5}) begin n_err++; $display("FAIL lbu_data done/data got %b %h want 1 000000a5", o_done_MEM, o_read_data_MEM); end
    tick;
    req_in(1'b1, 1'b0, 3'b001, 32'h0000_0042, 32'h0);
    tick; idle_in;
    i_dmem_ready = 1'b1; i_dmem_rdata = 32'h8001_0000;
    tick; i_dmem_ready = 1'b0;
    n_cmp++; if (o_read_data_MEM !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_data got %h want ffff8001", o_read_data_MEM); end
    tick;
    i_dmem_ready = 1'b1; i_dmem_rdata = 32'h1111_1111;
    tick; i_dmem_ready = 1'b0;
    n_cmp++; if ({o_done_MEM, o_read_data_MEM} !== {1'b0, 32'hFFFF_8001}) begin n_err++; $display("FAIL idle_ready_ignored done/data got %b %h want 0 ffff8001", o_done_MEM, o_read_data_MEM); end
  endtask
  initial begin
    i_rst = 1'b1; i_dmem_ready = 1'b0; i_dmem_rdata = 32'h0;
    i_funct3_MEM = 3'b000; i_alu_result_MEM = 32'h0; i_write_data_MEM = 32'h0;
    idle_in;
    test_reset;
    test_lb;
    test_sh;
    test_misaligned;
    test_both;
    test_timeout;
    test_reset_busy;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of BUSY cycles to wait for i_dmem_ready.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_valid_MEM, input, 1, an instruction is present in the MEM stage.
REQ-006 SHALL have port i_mem_read_MEM, input, 1, load request.
REQ-007 SHALL have port i_mem_write_MEM, input, 1, store request.
REQ-008 SHALL have port i_funct3_MEM, input, 3, access size/sign (RV32I load/store funct3).
REQ-009 SHALL have port i_alu_result_MEM, input, WIDTH, the effective byte address computed by the ALU.
REQ-010 SHALL have port i_write_data_MEM, input, WIDTH, the store data (rs2).
REQ-011 SHALL have port o_dmem_req, output, 1, data memory request.
REQ-012 SHALL have port o_dmem_we, output, 1, data memory write enable.
REQ-013 SHALL have port o_dmem_addr, output, WIDTH, word address {addr[31:2],2'b00}.
REQ-014 SHALL have port o_dmem_be, output, 4, byte enables.
REQ-015 SHALL have port o_dmem_wdata, output, WIDTH, lane-replicated store data.
REQ-016 SHALL have port i_dmem_ready, input, 1, memory completes the request; i_dmem_rdata is valid in the same cycle.
REQ-017 SHALL have port i_dmem_rdata, input, WIDTH, memory read word.
REQ-018 SHALL have port o_read_data_MEM, output, WIDTH, formatted load result.
REQ-019 SHALL have port o_done_MEM, output, 1, one-cycle pulse marking access completion.
REQ-020 SHALL have port o_stall_MEM, output, 1, holds the pipeline upstream of MEM.
REQ-021 SHALL have port o_fault_MEM, output, 1, one-cycle pulse for a misaligned, illegal or timed-out access.

Function
REQ-022 SHALL implement FSM states IDLE, BUSY, DONE, where an access is "accepted" when i_valid_MEM=1 and exactly one of read/write is set in IDLE.
REQ-023 SHALL define an accepted access as legal when funct3 is valid and the access is aligned: loads 000/001/010/100/101, stores 000/001/010; halfword needs addr[0]=0, word needs addr[1:0]=0.
REQ-024 On a legal accepted access in IDLE, SHALL latch address, funct3, write flag and data, then go to BUSY next edge.
REQ-025 On an illegal access in IDLE, or with both read and write set, SHALL issue no bus request, pulse o_fault_MEM in the next cycle and remain in IDLE.
REQ-026 In BUSY, SHALL hold o_dmem_req=1 and keep addr/we/be/wdata stable until i_dmem_ready=1, then go to DONE.
REQ-027 SHALL set store byte enables to SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111.
REQ-028 SHALL set o_dmem_wdata to {4{wd[7:0]}} for SB, {2{wd[15:0]}} for SH, and wd for SW.
REQ-029 Loads SHALL drive o_dmem_we=0 and be=4'b1111.
REQ-030 In the i_dmem_ready cycle of a load, SHALL capture into o_read_data_MEM the byte or half selected by addr[1:0]: LB/LH sign-extended, LBU/LHU zero-extended, LW the full word.
REQ-031 SHALL hold o_read_data_MEM until the next load completes; stores and faults leave it unchanged.
REQ-032 In DONE, SHALL hold o_done_MEM=1 for exactly one cycle, then return to IDLE; a new request is accepted in IDLE only, so the minimum interval between accesses is 3 cycles.
REQ-033 SHALL drive o_stall_MEM combinationally: 1 when in IDLE with a legal accepted access, 1 in BUSY, 0 in DONE and for illegal accesses.
REQ-034 SHALL count BUSY cycles from 0; if the count reaches TIMEOUT without i_dmem_ready, SHALL drop o_dmem_req, pulse o_fault_MEM, and go to IDLE with no done pulse.
REQ-035 SHALL ignore i_dmem_ready outside BUSY.
REQ-036 SHALL give i_dmem_ready priority over timeout in the same cycle.
REQ-037 SHALL drive o_dmem_req, o_dmem_we and o_dmem_be to 0 outside BUSY.

Reset
REQ-038 SHALL, when i_rst=1 at a clock edge, set state IDLE, counter 0, and o_read_data_MEM, o_done_MEM, o_fault_MEM, o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr and o_dmem_wdata to 0.
REQ-039 Reset asserted in BUSY SHALL abort the access, and i_dmem_ready arriving afterwards SHALL have no effect.

Verification
REQ-040 LB, addr 0x1003, rdata 0x80FF_0000, ready after 2 cycles: be=1111, o_dmem_addr=0x1000, o_read_data_MEM=0xFFFF_FF80, one done pulse.
REQ-041 SH, addr 0x2002, wd 0x1234_ABCD: be=1100, wdata=0xABCD_ABCD, we=1, stall high until DONE.
REQ-042 LW, addr 0x0006: no o_dmem_req, fault pulse the next cycle, stall stays 0.
REQ-043 LHU, addr 0x0002, ready never asserted with TIMEOUT=4: req high for 4 cycles, then fault pulse and IDLE.
REQ-044 i_rst in the 2nd BUSY cycle, then ready: req=0 after the reset edge, no done, o_read_data_MEM=0.
REQ-045 Read and write both set, funct3=010: fault pulse and no bus activity.
